// File: rtl/dpc_exec_pkg.sv
// ---------------------------------------------------------------------------
// dpc_exec_pkg
// Shared definitions for the data execution line of the decimal processor:
// opcode encodings, the execution FSM state enum and default BCD widths.
// No ports.
// ---------------------------------------------------------------------------
package dpc_exec_pkg;

    // Default widths, in BCD digits
    localparam int AP_DIGITS_DEF   = 3;
    localparam int DATA_DIGITS_DEF = 3;

    // Opcodes delivered by the fetch line; any other code executes as a no-op
    localparam logic [3:0] OP_NOP        = 4'h0;
    localparam logic [3:0] OP_INC        = 4'h1;
    localparam logic [3:0] OP_DEC        = 4'h2;
    localparam logic [3:0] OP_AP_INC     = 4'h3;
    localparam logic [3:0] OP_AP_DEC     = 4'h4;
    localparam logic [3:0] OP_LOOP_OPEN  = 4'h5;
    localparam logic [3:0] OP_LOOP_CLOSE = 4'h6;
    localparam logic [3:0] OP_OUT        = 4'h7;
    localparam logic [3:0] OP_IN         = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_OP = 3'd1,
        ST_MEM_WR  = 3'd2,
        ST_AP_OP   = 3'd3,
        ST_MEM_RD  = 3'd4,
        ST_IO_OUT  = 3'd5,
        ST_IO_IN   = 3'd6,
        ST_HALT    = 3'd7
    } exec_state_e;

endpackage

// File: rtl/bcd_updown_step.sv
// ---------------------------------------------------------------------------
// bcd_updown_step
// Adds or subtracts one from an N-digit packed BCD value, wrapping
// 99..9 -> 00..0 going up and 00..0 -> 99..9 going down.
// Ports:
//   value_i  [DIGITS*4] : BCD operand
//   down_i              : 1 = subtract one, 0 = add one
//   result_o [DIGITS*4] : BCD result
// ---------------------------------------------------------------------------
module bcd_updown_step #(
    parameter int DIGITS = 3
) (
    input  logic [DIGITS*4-1:0] value_i,
    input  logic                down_i,
    output logic [DIGITS*4-1:0] result_o
);

    logic       carry;
    logic [3:0] nib;

    // NOTE: every variable written here gets a value before any branch,
    // otherwise the missing paths infer latches.
    always_comb begin
        carry    = 1'b1;
        nib      = 4'd0;
        result_o = value_i;
        // Ripple the carry/borrow upward; digits above the first one that
        // absorbs it pass through unchanged.
        for (int d = 0; d < DIGITS; d++) begin
            nib = value_i[d*4 +: 4];
            if (carry) begin
                if (down_i) begin
                    if (nib == 4'd0) begin
                        result_o[d*4 +: 4] = 4'd9;
                    end else begin
                        result_o[d*4 +: 4] = nib - 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    // >= also folds any non-BCD code back to zero
                    if (nib >= 4'd9) begin
                        result_o[d*4 +: 4] = 4'd0;
                    end else begin
                        result_o[d*4 +: 4] = nib + 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/data_exec_line.sv
// ---------------------------------------------------------------------------
// data_exec_line
// Data execution line of the decimal processor: owns the address pointer
// (AP) and the current data cell, executes one opcode per Request, spills
// and refills the cell through the data RAM when AP moves, and services
// console I/O.
// Build option: define DATA_EXEC_IO_EN to enable console OUT/IN; without it
// OUT/IN are single-cycle no-ops and OutValid is held low.
// Ports:
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   HaltRq              : halt request, honoured only from IDLE
//   Request, Insn       : execute Insn (held until the line is Ready)
//   Ready               : IDLE and no Request pending
//   DataIsZeroed        : current cell is zero (combinational)
//   ApAddress, Data     : current AP and cell, BCD
//   MemWrReq/MemRdReq   : single-cycle RAM requests at ApAddress
//   MemWrData/MemRdData : RAM write / read data
//   MemReady            : RAM completion
//   OutValid/OutAck     : console output handshake (value is Data)
//   InValid/InData      : console input
// ---------------------------------------------------------------------------
module data_exec_line
    import dpc_exec_pkg::*;
#(
    parameter int AP_DIGITS   = AP_DIGITS_DEF,
    parameter int DATA_DIGITS = DATA_DIGITS_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     HaltRq,
    input  logic                     Request,
    input  logic [3:0]               Insn,
    output logic                     Ready,
    output logic                     DataIsZeroed,
    output logic [AP_DIGITS*4-1:0]   ApAddress,
    output logic [DATA_DIGITS*4-1:0] Data,
    output logic                     MemWrReq,
    output logic                     MemRdReq,
    output logic [DATA_DIGITS*4-1:0] MemWrData,
    input  logic [DATA_DIGITS*4-1:0] MemRdData,
    input  logic                     MemReady,
    output logic                     OutValid,
    input  logic                     OutAck,
    input  logic                     InValid,
    input  logic [DATA_DIGITS*4-1:0] InData
);

    exec_state_e state_q, state_d;

    logic [AP_DIGITS*4-1:0]   ap_q, ap_d, ap_step;
    logic [DATA_DIGITS*4-1:0] cell_q, cell_d, cell_step;
    logic [3:0]               op_q, op_d;
    logic                     armed_q, armed_d;       // Request seen low since last start
    logic                     req_sent_q, req_sent_d; // RAM request already pulsed in this state
    logic                     start_c;

    // A new operation needs Request to have been low since the previous one
    // started, so a Request held past completion does not re-execute.
    assign start_c = (state_q == ST_IDLE) && !HaltRq && Request && armed_q;

    bcd_updown_step #(.DIGITS(AP_DIGITS)) u_ap_step (
        .value_i  (ap_q),
        .down_i   (op_q == OP_AP_DEC),
        .result_o (ap_step)
    );

    bcd_updown_step #(.DIGITS(DATA_DIGITS)) u_cell_step (
        .value_i  (cell_q),
        .down_i   (op_q == OP_DEC),
        .result_o (cell_step)
    );

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // HaltRq wins over a simultaneous Request
                if (HaltRq) begin
                    state_d = ST_HALT;
                end else if (start_c) begin
                    case (Insn)
                        OP_AP_INC, OP_AP_DEC: state_d = ST_MEM_WR;
`ifdef DATA_EXEC_IO_EN
                        OP_OUT:               state_d = ST_IO_OUT;
                        OP_IN:                state_d = ST_IO_IN;
`endif
                        default:              state_d = ST_DATA_OP;
                    endcase
                end
            end
            ST_DATA_OP: state_d = ST_IDLE;
            ST_MEM_WR:  if (MemReady) state_d = ST_AP_OP;
            ST_AP_OP:   state_d = ST_MEM_RD;
            ST_MEM_RD:  if (MemReady) state_d = ST_IDLE;
`ifdef DATA_EXEC_IO_EN
            ST_IO_OUT:  if (OutAck)  state_d = ST_IDLE;
            ST_IO_IN:   if (InValid) state_d = ST_IDLE;
`else
            ST_IO_OUT:  state_d = ST_IDLE;
            ST_IO_IN:   state_d = ST_IDLE;
`endif
            ST_HALT:    if (!HaltRq) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        Ready    = (state_q == ST_IDLE) && !Request;
        MemWrReq = (state_q == ST_MEM_WR) && !req_sent_q;
        MemRdReq = (state_q == ST_MEM_RD) && !req_sent_q;
`ifdef DATA_EXEC_IO_EN
        OutValid = (state_q == ST_IO_OUT);
`else
        OutValid = 1'b0;
`endif
    end

`ifndef DATA_EXEC_IO_EN
    // Console inputs have no function in this build
    logic unused_io;
    assign unused_io = ^{OutAck, InValid, InData};
`endif

    assign ApAddress    = ap_q;
    assign Data         = cell_q;
    assign MemWrData    = cell_q;
    assign DataIsZeroed = (cell_q == '0);

    // ---------------- datapath next state ----------------
    always_comb begin
        ap_d       = ap_q;
        cell_d     = cell_q;
        op_d       = op_q;
        armed_d    = armed_q;
        req_sent_d = 1'b0;

        // Insn is only guaranteed while Request is high, so keep a copy
        if (start_c) begin
            op_d = Insn;
        end

        if (!Request) begin
            armed_d = 1'b1;
        end else if (start_c) begin
            armed_d = 1'b0;
        end

        // Request pulses on the first cycle of a RAM wait state only
        if ((state_q == ST_MEM_WR || state_q == ST_MEM_RD) && state_d == state_q) begin
            req_sent_d = 1'b1;
        end

        case (state_q)
            ST_DATA_OP: if (op_q == OP_INC || op_q == OP_DEC) cell_d = cell_step;
            ST_AP_OP:   ap_d = ap_step;
            ST_MEM_RD:  if (MemReady) cell_d = MemRdData;
`ifdef DATA_EXEC_IO_EN
            ST_IO_IN:   if (InValid) cell_d = InData;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ap_q       <= '0;
            cell_q     <= '0;
            op_q       <= OP_NOP;
            armed_q    <= 1'b0;
            req_sent_q <= 1'b0;
        end else begin
            ap_q       <= ap_d;
            cell_q     <= cell_d;
            op_q       <= op_d;
            armed_q    <= armed_d;
            req_sent_q <= req_sent_d;
        end
    end

endmodule

// File: tb/tb_data_exec_line.sv
// ---------------------------------------------------------------------------
// tb_data_exec_line
// Scoreboarded bench for data_exec_line. Stimulus pushes expected
// completions and RAM transactions into queues; monitors pop and compare
// whenever Ready rises or a RAM request appears.
// ---------------------------------------------------------------------------
module tb_data_exec_line;
    import dpc_exec_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        HaltRq = 1'b0;
    logic        Request = 1'b0;
    logic [3:0]  Insn = OP_NOP;
    logic        Ready, DataIsZeroed;
    logic [11:0] ApAddress, Data;
    logic        MemWrReq, MemRdReq;
    logic [11:0] MemWrData, MemRdData;
    logic        MemReady;
    logic        OutValid;
    logic        OutAck = 1'b0;
    logic        InValid = 1'b0;
    logic [11:0] InData = 12'h000;

    data_exec_line #(.AP_DIGITS(3), .DATA_DIGITS(3)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .HaltRq       (HaltRq),
        .Request      (Request),
        .Insn         (Insn),
        .Ready        (Ready),
        .DataIsZeroed (DataIsZeroed),
        .ApAddress    (ApAddress),
        .Data         (Data),
        .MemWrReq     (MemWrReq),
        .MemRdReq     (MemRdReq),
        .MemWrData    (MemWrData),
        .MemRdData    (MemRdData),
        .MemReady     (MemReady),
        .OutValid     (OutValid),
        .OutAck       (OutAck),
        .InValid      (InValid),
        .InData       (InData)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- RAM responder ----------------
    logic [11:0] rd_value = 12'h000;
    int          wr_delay = 0;
    int          rd_delay = 0;
    int          mem_cnt;

    assign MemRdData = rd_value;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem_cnt  <= 0;
            MemReady <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            if (MemWrReq || MemRdReq) begin
                mem_cnt <= (MemWrReq ? wr_delay : rd_delay) + 1;
            end else if (mem_cnt == 1) begin
                MemReady <= 1'b1;
                mem_cnt  <= 0;
            end else if (mem_cnt > 1) begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [11:0] ap; logic [11:0] data; } done_t;
    typedef struct { logic is_wr; logic [11:0] addr; logic [11:0] data; } mem_t;

    done_t done_q[$];
    mem_t  mem_q[$];
    done_t done_e;
    mem_t  mem_e;
    logic  ready_prev = 1'b1;

    always @(negedge Clk) begin
        if (Ready && !ready_prev) begin
            if (done_q.size() == 0) begin
                fail_now("done_unexpected", $sformatf("Ready rose with ap=%h data=%h", ApAddress, Data));
            end else begin
                done_e = done_q.pop_front();
                check("done_ap", ApAddress, done_e.ap);
                check("done_data", Data, done_e.data);
                check("done_zero", DataIsZeroed, (done_e.data == 12'h000));
            end
        end
        ready_prev <= Ready;

        if (MemWrReq || MemRdReq) begin
            if (mem_q.size() == 0) begin
                fail_now("mem_unexpected", $sformatf("wr=%b rd=%b ap=%h", MemWrReq, MemRdReq, ApAddress));
            end else begin
                mem_e = mem_q.pop_front();
                check("mem_kind_wr", MemWrReq, mem_e.is_wr);
                check("mem_addr", ApAddress, mem_e.addr);
                if (mem_e.is_wr) check("mem_wr_data", MemWrData, mem_e.data);
            end
        end

        if (Rst_n) check("req_exclusive", (32'(MemWrReq) + 32'(MemRdReq) + 32'(OutValid)) <= 1, 1);
    end

    // ---------------- stimulus helpers ----------------
    logic [11:0] cur_ap   = 12'h000;
    logic [11:0] cur_data = 12'h000;

    task automatic issue(input logic [3:0] insn, input int hold);
        @(posedge Clk); #2;
        Insn    = insn;
        Request = 1'b1;
        repeat (hold) @(posedge Clk);
        #2 Request = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (Ready) break;
        end
        if (n == 100) fail_now(name, "Ready timeout");
    endtask

    task automatic run_op(input logic [3:0] insn, input logic [11:0] rd, input logic [11:0] exp_ap,
                          input logic [11:0] exp_data, input string name);
        rd_value = rd;
        if (insn == OP_AP_INC || insn == OP_AP_DEC) begin
            mem_q.push_back('{1'b1, cur_ap, cur_data});
            mem_q.push_back('{1'b0, exp_ap, 12'h000});
        end
        done_q.push_back('{exp_ap, exp_data});
        issue(insn, 1);
        wait_ready(name);
        cur_ap   = exp_ap;
        cur_data = exp_data;
    endtask

    typedef struct packed { logic [3:0] insn; logic [11:0] rd; logic [11:0] ap; logic [11:0] data; } vec_t;
    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs = '{
            '{OP_INC,        12'h000, 12'h000, 12'h001},
            '{OP_INC,        12'h000, 12'h000, 12'h002},
            '{OP_INC,        12'h000, 12'h000, 12'h003},
            '{OP_DEC,        12'h000, 12'h000, 12'h002},
            '{OP_DEC,        12'h000, 12'h000, 12'h001},
            '{OP_DEC,        12'h000, 12'h000, 12'h000},
            '{OP_DEC,        12'h000, 12'h000, 12'h999},
            '{OP_INC,        12'h000, 12'h000, 12'h000},
            '{OP_AP_DEC,     12'h123, 12'h999, 12'h123},
            '{OP_AP_INC,     12'h009, 12'h000, 12'h009},
            '{OP_INC,        12'h000, 12'h000, 12'h010},
            '{OP_DEC,        12'h000, 12'h000, 12'h009},
            '{OP_AP_INC,     12'h099, 12'h001, 12'h099},
            '{OP_INC,        12'h000, 12'h001, 12'h100},
            '{OP_DEC,        12'h000, 12'h001, 12'h099},
            '{OP_NOP,        12'h000, 12'h001, 12'h099},
            '{OP_LOOP_OPEN,  12'h000, 12'h001, 12'h099},
            '{OP_LOOP_CLOSE, 12'h000, 12'h001, 12'h099},
            '{4'hF,          12'h000, 12'h001, 12'h099},
            '{OP_AP_INC,     12'h000, 12'h002, 12'h000},
            '{OP_AP_INC,     12'h000, 12'h003, 12'h000},
            '{OP_AP_INC,     12'h000, 12'h004, 12'h000},
            '{OP_AP_INC,     12'h042, 12'h005, 12'h042}
        };

        // Reset state
        repeat (3) @(posedge Clk);
        #2;
        check("rst_ready", Ready, 1);
        check("rst_ap", ApAddress, 12'h000);
        check("rst_data", Data, 12'h000);
        check("rst_zero", DataIsZeroed, 1);
        check("rst_memwr", MemWrReq, 0);
        check("rst_memrd", MemRdReq, 0);
        check("rst_outvalid", OutValid, 0);
        Rst_n = 1'b1;

        // Directed vector table: INC/DEC, BCD wrap and carry, no-ops, AP moves
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].insn, vecs[i].rd, vecs[i].ap, vecs[i].data, $sformatf("vec%0d", i));
        end

        // Spill 042 at 005 with a slow RAM, refill 017 from 006
        wr_delay = 3;
        rd_delay = 3;
        run_op(OP_AP_INC, 12'h017, 12'h006, 12'h017, "ap_inc_slow");
        wr_delay = 0;
        rd_delay = 0;

        // Request held for several cycles executes exactly once
        done_q.push_back('{12'h006, 12'h018});
        issue(OP_INC, 3);
        wait_ready("held_request");
        cur_data = 12'h018;

        // HaltRq and Request together: halt wins, nothing executes
        done_q.push_back('{12'h006, 12'h018});
        @(posedge Clk); #2;
        HaltRq  = 1'b1;
        Insn    = OP_INC;
        Request = 1'b1;
        @(posedge Clk); #2;
        Request = 1'b0;
        repeat (3) @(negedge Clk);
        check("halt_ready_low", Ready, 0);
        check("halt_no_op", Data, 12'h018);
        @(posedge Clk); #2;
        HaltRq = 1'b0;
        wait_ready("halt_exit");
        run_op(OP_INC, 12'h000, 12'h006, 12'h019, "after_halt");

        // HaltRq during an AP move is deferred until IDLE
        rd_delay = 4;
        rd_value = 12'h555;
        mem_q.push_back('{1'b1, 12'h006, 12'h019});
        mem_q.push_back('{1'b0, 12'h007, 12'h000});
        done_q.push_back('{12'h007, 12'h555});
        done_q.push_back('{12'h007, 12'h555});
        issue(OP_AP_INC, 1);
        HaltRq = 1'b1;
        wait_ready("halt_deferred_done");
        @(negedge Clk);
        check("halt_deferred_ready_low", Ready, 0);
        @(posedge Clk); #2;
        HaltRq = 1'b0;
        wait_ready("halt_deferred_exit");
        cur_ap   = 12'h007;
        cur_data = 12'h555;
        rd_delay = 0;

`ifdef DATA_EXEC_IO_EN
        // OUT: OutValid held until the ack edge
        done_q.push_back('{cur_ap, cur_data});
        issue(OP_OUT, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("out_valid_wait", OutValid, 1);
            check("out_value", Data, 12'h555);
        end
        @(posedge Clk); #2;
        OutAck = 1'b1;
        @(negedge Clk);
        check("out_valid_at_ack", OutValid, 1);
        @(posedge Clk); #2;
        OutAck = 1'b0;
        @(negedge Clk);
        check("out_valid_after_ack", OutValid, 0);
        wait_ready("out_done");

        // IN: wait for InValid, load InData
        done_q.push_back('{cur_ap, 12'h321});
        issue(OP_IN, 1);
        @(negedge Clk);
        check("in_wait_data", Data, 12'h555);
        @(posedge Clk); #2;
        InValid = 1'b1;
        InData  = 12'h321;
        @(posedge Clk); #2;
        InValid = 1'b0;
        wait_ready("in_done");
        cur_data = 12'h321;
`else
        // OUT/IN degrade to one-cycle no-ops
        done_q.push_back('{cur_ap, cur_data});
        issue(OP_OUT, 1);
        @(negedge Clk);
        check("out_noop_valid", OutValid, 0);
        check("out_noop_busy", Ready, 0);
        @(negedge Clk);
        check("out_noop_ready", Ready, 1);
        check("out_noop_valid2", OutValid, 0);
        run_op(OP_IN, 12'h000, cur_ap, cur_data, "in_noop");
`endif

        // Reset while waiting in MEM_RD
        rd_delay = 30;
        mem_q.push_back('{1'b1, cur_ap, cur_data});
        mem_q.push_back('{1'b0, 12'h008, 12'h000});
        done_q.push_back('{12'h000, 12'h000});
        issue(OP_AP_INC, 1);
        begin
            int n;
            for (n = 0; n < 40; n++) begin
                @(negedge Clk);
                if (MemRdReq) break;
            end
            if (n == 40) fail_now("rst_memrd_seen", "MemRdReq timeout");
        end
        repeat (2) @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        check("async_rst_ap", ApAddress, 12'h000);
        check("async_rst_data", Data, 12'h000);
        check("async_rst_zero", DataIsZeroed, 1);
        check("async_rst_memrd", MemRdReq, 0);
        check("async_rst_memwr", MemWrReq, 0);
        check("async_rst_outvalid", OutValid, 0);
        check("async_rst_ready", Ready, 1);
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        cur_ap   = 12'h000;
        cur_data = 12'h000;
        rd_delay = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            check("post_rst_no_memrd", MemRdReq, 0);
        end

        run_op(OP_INC, 12'h000, 12'h000, 12'h001, "post_rst_inc");

        repeat (3) @(negedge Clk);
        check("done_q_empty", done_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
